// File: rtl/vx_sched_csr_ctrl.sv
// ---------------------------------------------------------------------------
// vx_sched_csr_ctrl
//
// Scheduler-side master of the scheduler/CSR handshake. Sits beside the issue
// stage and provides the CSR unit with what it needs to fence a warp:
//   * per-warp in-flight instruction counters (issue increments, commit
//     decrements) and the alm_empty answer for the warp the CSR unit queries;
//   * a per-warp lock that is set when a warp issues an FPU CSR access and
//     released when the CSR unit signals unlock_warp;
//   * the free-running cycles counter.
//
// Optional feature macro: SCHED_CSR_STALL_PERF_EN
//   When defined, adds perf_fence_stalls, a saturating count of cycles in
//   which a valid issue was held back because its warp was locked.
//
// Ports
//   clk               in   core clock
//   reset             in   asynchronous, active-high
//   issue_valid       in   instruction offered for issue this cycle
//   issue_wid         in   warp of the offered instruction
//   issue_fpu_csr     in   offered instruction is an FPU CSR access
//   issue_ready       out  issue of issue_wid permitted (from registers only)
//   commit_valid      in   one instruction of commit_wid retired
//   commit_wid        in   warp of the retiring instruction
//   alm_empty_wid     in   warp queried by the CSR unit
//   alm_empty         out  pending[alm_empty_wid] <= ALM_EMPTY_TH
//   unlock_warp       in   CSR unit releases a fenced warp
//   unlock_wid        in   warp to release
//   warp_locked       out  registered per-warp lock bits
//   cycles            out  cycles since reset, wraps
//   underflow_err     out  sticky: commit seen while a counter was 0
//   perf_fence_stalls out  (macro only) lock-induced issue stall cycles
// ---------------------------------------------------------------------------
module vx_sched_csr_ctrl #(
    parameter int NUM_WARPS    = 4,
    parameter int MAX_PENDING  = 15,
    parameter int ALM_EMPTY_TH = 1,
    parameter int CYCLE_W      = 64,
    parameter int WID_W        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int PEND_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [WID_W-1:0]     issue_wid,
    input  logic                 issue_fpu_csr,
    output logic                 issue_ready,
    input  logic                 commit_valid,
    input  logic [WID_W-1:0]     commit_wid,
    input  logic [WID_W-1:0]     alm_empty_wid,
    output logic                 alm_empty,
    input  logic                 unlock_warp,
    input  logic [WID_W-1:0]     unlock_wid,
    output logic [NUM_WARPS-1:0] warp_locked,
    output logic [CYCLE_W-1:0]   cycles,
    output logic                 underflow_err
`ifdef SCHED_CSR_STALL_PERF_EN
    ,
    output logic [43:0]          perf_fence_stalls
`endif
);

    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);
    localparam logic [PEND_W-1:0] PEND_TH  = PEND_W'(ALM_EMPTY_TH);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t              lock_q [NUM_WARPS];
    lock_state_t              lock_d [NUM_WARPS];
    logic [PEND_W-1:0]        pending [NUM_WARPS];

    // One-hot decodes of each wid input. Comparing against every legal warp
    // index means an out-of-range wid simply decodes to all zeros, which gives
    // the "ignored / not ready / not empty" behaviour without any array index
    // ever going out of bounds.
    logic [NUM_WARPS-1:0]     issue_hit;
    logic [NUM_WARPS-1:0]     commit_hit;
    logic [NUM_WARPS-1:0]     unlock_hit;
    logic [NUM_WARPS-1:0]     query_hit;
    logic [NUM_WARPS-1:0]     full;
    logic [NUM_WARPS-1:0]     low;
    logic [NUM_WARPS-1:0]     inc;
    logic [NUM_WARPS-1:0]     dec;
    logic                     issue_fire;
    logic                     stall_locked;

    // ------------------------------------------------------------------
    // Decode and combinational outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any conditional update,
        // so no path through the block leaves a value unassigned (no latch).
        issue_hit  = '0;
        commit_hit = '0;
        unlock_hit = '0;
        query_hit  = '0;
        full       = '0;
        low        = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            issue_hit[w]  = (issue_wid == WID_W'(w));
            commit_hit[w] = commit_valid & (commit_wid == WID_W'(w));
            unlock_hit[w] = unlock_warp & (unlock_wid == WID_W'(w));
            query_hit[w]  = (alm_empty_wid == WID_W'(w));
            full[w]       = (pending[w] == PEND_MAX);
            low[w]        = (pending[w] <= PEND_TH);
        end

        // Ready depends only on registered state, never on issue_valid,
        // so the issue stage can use it without a combinational loop.
        issue_ready  = |(issue_hit & ~warp_locked & ~full);
        issue_fire   = issue_valid & issue_ready;
        inc          = issue_fire ? issue_hit : '0;
        dec          = commit_hit;

        // No bypass: the query sees the registered count only.
        alm_empty    = |(query_hit & low);

        stall_locked = issue_valid & ~issue_ready & |(issue_hit & warp_locked);
    end

    // ------------------------------------------------------------------
    // Lock FSM, one per warp: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            lock_d[w] = lock_q[w];
            unique case (lock_q[w])
                UNLOCKED: if (inc[w] && issue_fpu_csr) lock_d[w] = LOCKED;
                LOCKED:   if (unlock_hit[w])           lock_d[w] = UNLOCKED;
                default:  lock_d[w] = UNLOCKED;
            endcase
            // A lock request in the same cycle as an unlock always wins.
            if (inc[w] && issue_fpu_csr) lock_d[w] = LOCKED;
        end
    end

    // Lock FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) lock_q[w] <= UNLOCKED;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            for (int w = 0; w < NUM_WARPS; w++) lock_q[w] <= lock_d[w];
        end
    end

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) warp_locked[w] = (lock_q[w] == LOCKED);
    end

    // ------------------------------------------------------------------
    // Pending counters and sticky underflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the counter array is a small bank of flops, not a RAM,
            // so it is reset element by element like any other register.
            for (int w = 0; w < NUM_WARPS; w++) pending[w] <= '0;
            underflow_err <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                unique case ({inc[w], dec[w]})
                    2'b10: pending[w] <= pending[w] + PEND_W'(1);
                    2'b01: begin
                        if (pending[w] == '0) underflow_err <= 1'b1;
                        else                  pending[w]    <= pending[w] - PEND_W'(1);
                    end
                    default: pending[w] <= pending[w];
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Free-running cycles counter (wraps naturally)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cycles <= '0;
        else       cycles <= cycles + CYCLE_W'(1);
    end

`ifdef SCHED_CSR_STALL_PERF_EN
    // ------------------------------------------------------------------
    // Saturating count of issue cycles lost to a warp fence
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fence_stalls <= '0;
        end else if (stall_locked && !(&perf_fence_stalls)) begin
            perf_fence_stalls <= perf_fence_stalls + 44'd1;
        end
    end
`else
    logic unused_stall;
    assign unused_stall = stall_locked;
`endif

endmodule

// File: tb/tb_vx_sched_csr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vx_sched_csr_ctrl
//
// Directed bench for vx_sched_csr_ctrl. The main instance uses the default
// parameters; a second instance with NUM_WARPS=3 and CYCLE_W=4 shares the
// same stimulus so that out-of-range wids and counter wrap are observable.
// Pending counts are observed through alm_empty by draining a warp one commit
// at a time and checking alm_empty at every level.
// ---------------------------------------------------------------------------
module tb_vx_sched_csr_ctrl;

    localparam int NW    = 4;
    localparam int WW    = 2;
    localparam int ALMTH = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          issue_valid;
    logic [WW-1:0] issue_wid;
    logic          issue_fpu_csr;
    logic          issue_ready;
    logic          commit_valid;
    logic [WW-1:0] commit_wid;
    logic [WW-1:0] alm_empty_wid;
    logic          alm_empty;
    logic          unlock_warp;
    logic [WW-1:0] unlock_wid;
    logic [NW-1:0] warp_locked;
    logic [63:0]   cycles;
    logic          underflow_err;

    logic          issue_ready_s;
    logic          alm_empty_s;
    logic [2:0]    warp_locked_s;
    logic [3:0]    cycles_s;
    logic          underflow_err_s;

`ifdef SCHED_CSR_STALL_PERF_EN
    logic [43:0]   perf_fence_stalls;
    logic [43:0]   perf_fence_stalls_s;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vx_sched_csr_ctrl #(
        .NUM_WARPS(NW), .MAX_PENDING(15), .ALM_EMPTY_TH(ALMTH), .CYCLE_W(64)
    ) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_wid(issue_wid),
        .issue_fpu_csr(issue_fpu_csr), .issue_ready(issue_ready),
        .commit_valid(commit_valid), .commit_wid(commit_wid),
        .alm_empty_wid(alm_empty_wid), .alm_empty(alm_empty),
        .unlock_warp(unlock_warp), .unlock_wid(unlock_wid),
        .warp_locked(warp_locked), .cycles(cycles),
        .underflow_err(underflow_err)
`ifdef SCHED_CSR_STALL_PERF_EN
        , .perf_fence_stalls(perf_fence_stalls)
`endif
    );

    vx_sched_csr_ctrl #(
        .NUM_WARPS(3), .MAX_PENDING(15), .ALM_EMPTY_TH(ALMTH), .CYCLE_W(4)
    ) dut_small (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_wid(issue_wid),
        .issue_fpu_csr(issue_fpu_csr), .issue_ready(issue_ready_s),
        .commit_valid(commit_valid), .commit_wid(commit_wid),
        .alm_empty_wid(alm_empty_wid), .alm_empty(alm_empty_s),
        .unlock_warp(unlock_warp), .unlock_wid(unlock_wid),
        .warp_locked(warp_locked_s), .cycles(cycles_s),
        .underflow_err(underflow_err_s)
`ifdef SCHED_CSR_STALL_PERF_EN
        , .perf_fence_stalls(perf_fence_stalls_s)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_issue(input logic [WW-1:0] wid, input logic fpu);
        issue_valid   = 1'b1;
        issue_wid     = wid;
        issue_fpu_csr = fpu;
        tick();
        issue_valid   = 1'b0;
        issue_fpu_csr = 1'b0;
    endtask

    task automatic do_commit(input logic [WW-1:0] wid);
        commit_valid = 1'b1;
        commit_wid   = wid;
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic do_unlock(input logic [WW-1:0] wid);
        unlock_warp = 1'b1;
        unlock_wid  = wid;
        tick();
        unlock_warp = 1'b0;
    endtask

    // Drain warp wid from an expected count p down to 0, checking alm_empty
    // at each level; a count off by one in either direction shows up.
    task automatic expect_pending(input logic [WW-1:0] wid, input int p);
        alm_empty_wid = wid;
        for (int k = p; k >= 0; k--) begin
            #1;
            check($sformatf("pend_w%0d_k%0d", wid, k), 64'(alm_empty), (k <= ALMTH) ? 64'd1 : 64'd0);
            if (k > 0) do_commit(wid);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        issue_valid   = 1'b0;
        issue_wid     = '0;
        issue_fpu_csr = 1'b0;
        commit_valid  = 1'b0;
        commit_wid    = '0;
        alm_empty_wid = '0;
        unlock_warp   = 1'b0;
        unlock_wid    = '0;

        // Outputs while reset is held
        #2;
        check("rst_locked",    64'(warp_locked),   64'h0);
        check("rst_cycles",    cycles,             64'h0);
        check("rst_underflow", 64'(underflow_err), 64'h0);
        check("rst_ready",     64'(issue_ready),   64'h1);
        check("rst_alm_empty", 64'(alm_empty),     64'h1);

        ticks(2);
        reset = 1'b0;

        // Cycles count from deassertion; the 4-bit instance wraps after 16
        ticks(3);
        check("cycles_3",       cycles,          64'd3);
        check("cycles_s_3",     64'(cycles_s),   64'd3);
        ticks(13);
        check("cycles_16",      cycles,          64'd16);
        check("cycles_s_wrap0", 64'(cycles_s),   64'd0);
        tick();
        check("cycles_s_wrap1", 64'(cycles_s),   64'd1);

        // T1: reset mid-run
        for (int i = 0; i < 5; i++) do_issue(2, 1'b0);
        do_issue(1, 1'b1);
        check("t1_locked_pre", 64'(warp_locked), 64'b0010);
        reset = 1'b1;
        #1;
        check("t1_async_locked", 64'(warp_locked), 64'h0);
        check("t1_async_cycles", cycles,           64'h0);
        tick();
        reset = 1'b0;
        alm_empty_wid = 2;
        issue_wid     = 1;
        #1;
        check("t1_w2_empty", 64'(alm_empty),   64'h1);
        check("t1_w1_ready", 64'(issue_ready), 64'h1);
        tick();
        check("t1_cycles_1", cycles, 64'd1);

        // T2: three issues then two commits on warp 1
        for (int i = 0; i < 3; i++) do_issue(1, 1'b0);
        alm_empty_wid = 1;
        #1;
        check("t2_alm_p3", 64'(alm_empty), 64'h0);
        do_commit(1);
        // Commit presented but not yet clocked: no bypass into alm_empty
        commit_valid = 1'b1;
        commit_wid   = 1;
        #1;
        check("t2_no_bypass", 64'(alm_empty), 64'h0);
        tick();
        commit_valid = 1'b0;
        check("t2_alm_p1", 64'(alm_empty), 64'h1);
        do_commit(1);
        check("t2_alm_p0", 64'(alm_empty), 64'h1);
        check("t2_no_underflow", 64'(underflow_err), 64'h0);

        // T3: FPU CSR issue locks warp 0 until unlock
        do_issue(0, 1'b1);
        check("t3_locked", 64'(warp_locked), 64'b0001);
        issue_wid = 0;
        #1;
        check("t3_ready_w0", 64'(issue_ready), 64'h0);
        do_issue(0, 1'b0);                       // dropped: warp 0 is locked
        issue_wid = 1;
        #1;
        check("t3_ready_w1", 64'(issue_ready), 64'h1);
        do_unlock(0);
        check("t3_unlocked", 64'(warp_locked), 64'h0);
        issue_wid = 0;
        #1;
        check("t3_ready_w0_again", 64'(issue_ready), 64'h1);
        expect_pending(0, 1);
        // Lock and unlock of warp 3 in the same cycle: lock wins
        issue_valid   = 1'b1;
        issue_wid     = 3;
        issue_fpu_csr = 1'b1;
        unlock_warp   = 1'b1;
        unlock_wid    = 3;
        tick();
        issue_valid   = 1'b0;
        issue_fpu_csr = 1'b0;
        unlock_warp   = 1'b0;
        check("t3_lock_wins", 64'(warp_locked), 64'b1000);
        do_unlock(2);
        check("t3_unlock_noop", 64'(warp_locked), 64'b1000);
        do_unlock(3);
        check("t3_w3_unlocked", 64'(warp_locked), 64'h0);
        expect_pending(3, 1);

        // T4: simultaneous issue and commit
        issue_wid     = 3;
        alm_empty_wid = 3;
        #1;
        check("t4_small_oor_ready", 64'(issue_ready_s), 64'h0);
        check("t4_small_oor_alm",   64'(alm_empty_s),   64'h0);
        check("t4_main_w3_alm",     64'(alm_empty),     64'h1);
        for (int i = 0; i < 4; i++) do_issue(3, 1'b0);
        for (int i = 0; i < 4; i++) do_issue(2, 1'b0);
        issue_valid  = 1'b1;
        issue_wid    = 3;
        commit_valid = 1'b1;
        commit_wid   = 3;
        tick();                                  // same wid: stays 4
        issue_wid    = 2;
        tick();                                  // wid 2 up, wid 3 down
        issue_valid  = 1'b0;
        commit_valid = 1'b0;
        expect_pending(3, 3);
        expect_pending(2, 5);
        check("t4_no_underflow", 64'(underflow_err), 64'h0);

        // T5: fill warp 2, then underflow
        for (int i = 0; i < 15; i++) do_issue(2, 1'b0);
        issue_wid = 2;
        #1;
        check("t5_full_ready", 64'(issue_ready), 64'h0);
        do_issue(2, 1'b0);                       // 16th issue is dropped
        expect_pending(2, 15);
        check("t5_pre_underflow", 64'(underflow_err), 64'h0);
        do_commit(2);
        check("t5_underflow", 64'(underflow_err), 64'h1);
        alm_empty_wid = 2;
        #1;
        check("t5_held_at_0", 64'(alm_empty), 64'h1);
        ticks(2);
        check("t5_sticky", 64'(underflow_err), 64'h1);

`ifdef SCHED_CSR_STALL_PERF_EN
        // T6: fence stall counter
        reset = 1'b1;
        #1;
        check("t6_perf_rst", 64'(perf_fence_stalls), 64'h0);
        tick();
        reset = 1'b0;
        do_issue(0, 1'b1);
        issue_valid = 1'b1;
        issue_wid   = 0;
        ticks(10);
        issue_valid = 1'b0;
        check("t6_perf_10", 64'(perf_fence_stalls), 64'd10);
        ticks(2);
        check("t6_perf_hold", 64'(perf_fence_stalls), 64'd10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
